mips_multicycle_ctrl: RTL

- Main control FSM for the multicycle MIPS datapath.
- Sequences the shared ALU, memory port, IR, PC and register file through FETCH/DECODE/EXEC/MEM/WB steps.
- Drives the 4-bit ALU control code directly. Encodings: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111.
- Handles variable-latency memory with a ready handshake and a timeout watchdog.

---
 rtl/mips_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute
// steps, drives ALU control directly, and guards variable-latency memory with a watchdog.
module mips_multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic [5:0]       funct_q;
  logic             wait_state;
  logic             expire;
  logic             r_funct_ok;
  logic             pc_write;
  logic             pc_write_cond;

  always_comb begin
    r_funct_ok = 1'b0;
    case (funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: r_funct_ok = 1'b1;
      default:                           r_funct_ok = 1'b0;
    endcase
  end

  // The watchdog only runs in states that wait on mem_ready; a ready in the expiry cycle still wins.
  always_comb begin
    wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    expire     = (TIMEOUT != 0) && wait_state && !mem_ready && (wait_cnt == CNT_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      wait_cnt <= '0;
      funct_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        funct_q <= funct;
      end
      if (wait_state && !mem_ready && !expire && (state_d == state_q)) begin
        if (wait_cnt != CNT_MAX) begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_AND;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    mem_err       = 1'b0;
    pc_en         = 1'b0;
    state         = state_q;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (expire) begin
          mem_err = 1'b1;
          state_d = FETCH;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if (r_funct_ok) begin
              state_d = R_EXEC;
            end else begin
              illegal = 1'b1;
              state_d = FETCH;
            end
          end
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = I_EXEC;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        if (opcode == OP_LW) begin
          state_d = MEM_RD;
        end else if (opcode == OP_SW) begin
          state_d = MEM_WR;
        end else begin
          state_d = FETCH;
        end
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = MEM_WB;
        end else if (expire) begin
          mem_err = 1'b1;
          state_d = FETCH;
        end
      end
      // The write strobe is held while waiting and dropped only in an expiry cycle.
      MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = !expire;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (expire) begin
          mem_err = 1'b1;
          state_d = FETCH;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        case (funct_q)
          6'h20:   alu_ctrl = ALU_ADD;
          6'h22:   alu_ctrl = ALU_SUB;
          6'h24:   alu_ctrl = ALU_AND;
          6'h25:   alu_ctrl = ALU_OR;
          6'h2A:   alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_AND;
        endcase
        state_d = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase

    pc_en = pc_write | (pc_write_cond & zero);

    // Reset silences every strobe in the same cycle so a half-finished instruction commits nothing.
    if (reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_source  = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 4'b0000;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
      state      = 4'd0;
    end
  end

endmodule
